// File: rtl/scope_reader.sv
// Drain engine for the on-chip scope capture buffer: arms the scope, polls for a valid capture, then
// streams the header and every (delta, data) record. Optional poll timeout: SCOPE_READER_TIMEOUT_EN.
module scope_reader #(
   parameter int BUSW     = 64,
   parameter int CNTW     = 16,
   parameter int POLL_GAP = 16,
   parameter int TIMEOUT  = 65535
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [BUSW-4:0] delay_val,
   input  logic [BUSW-4:0] stop_addr,
   output logic [BUSW-1:0] bus_in,
   output logic            bus_write,
   output logic            bus_read,
   input  logic [BUSW-1:0] bus_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BUSW-1:0] out_data,
   output logic [1:0]      out_tag,
   output logic            out_last,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam logic [2:0] CMD_GET_VALID  = 3'd0;
   localparam logic [2:0] CMD_GET_DATA   = 3'd1;
   localparam logic [2:0] CMD_GET_WIDTH  = 3'd2;
   localparam logic [2:0] CMD_GET_COUNT  = 3'd3;
   localparam logic [2:0] CMD_SET_DELAY  = 3'd4;
   localparam logic [2:0] CMD_SET_STOP   = 3'd5;
   localparam logic [2:0] CMD_GET_OFFSET = 3'd6;

   localparam logic [1:0] TAG_HDR   = 2'd0;
   localparam logic [1:0] TAG_DELTA = 2'd1;
   localparam logic [1:0] TAG_DATA  = 2'd2;

   localparam int SHW  = $clog2(BUSW);
   localparam int GAPW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

   typedef enum logic [3:0] {
      IDLE, W_DELAY, W_STOP, S_VALID, R_VALID, GAP, S_WIDTH, R_WIDTH,
      S_COUNT, R_COUNT, S_OFFSET, R_OFFSET, S_DATA, R_DATA, DONE
   } state_t;

   state_t             state_reg, state_next;
   logic               out_valid_reg, out_valid_next;
   logic [BUSW-1:0]    out_data_reg, out_data_next;
   logic [1:0]         out_tag_reg, out_tag_next;
   logic               out_last_reg, out_last_next;
   logic               done_reg, done_next;
   logic [GAPW-1:0]    gap_cnt_reg, gap_cnt_next;
   logic [CNTW-1:0]    wps_reg, wps_next;
   logic [CNTW-1:0]    count_reg, count_next;
   logic [CNTW-1:0]    word_idx_reg, word_idx_next;
   logic [CNTW-1:0]    sample_idx_reg, sample_idx_next;
   logic               out_free;
   logic               last_word;
   logic [CNTW:0]      chunk_sum, chunks;
   logic [CNTW-1:0]    wps_calc;

`ifdef SCOPE_READER_TIMEOUT_EN
   localparam int PCW = $clog2(TIMEOUT + 1);
   logic [PCW-1:0]     poll_cnt_reg, poll_cnt_next;
   logic               err_reg, err_next;
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

   // Words per sample: one delta word plus at least one data chunk of BUSW bits.
   assign chunk_sum = {1'b0, bus_out[CNTW-1:0]} + (CNTW+1)'(BUSW - 1);
   assign chunks    = chunk_sum >> SHW;
   assign wps_calc  = (chunks == '0) ? CNTW'(2) : CNTW'(chunks + 1'b1);

   assign out_free  = !out_valid_reg || out_ready;
   assign last_word = (sample_idx_reg == count_reg - 1'b1) && (word_idx_reg == wps_reg - 1'b1);

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_tag   = out_tag_reg;
   assign out_last  = out_last_reg;
   assign done      = done_reg;
   assign busy      = (state_reg != IDLE);

   always_comb begin
      state_next      = state_reg;
      bus_in          = '0;
      bus_write       = 1'b0;
      bus_read        = 1'b0;
      out_valid_next  = out_valid_reg && !out_ready;
      out_data_next   = out_data_reg;
      out_tag_next    = out_tag_reg;
      out_last_next   = out_last_reg;
      done_next       = 1'b0;
      gap_cnt_next    = gap_cnt_reg;
      wps_next        = wps_reg;
      count_next      = count_reg;
      word_idx_next   = word_idx_reg;
      sample_idx_next = sample_idx_reg;
`ifdef SCOPE_READER_TIMEOUT_EN
      poll_cnt_next   = poll_cnt_reg;
      err_next        = err_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = W_DELAY;
`ifdef SCOPE_READER_TIMEOUT_EN
               err_next      = 1'b0;
               poll_cnt_next = '0;
`endif
            end
         end
         W_DELAY: begin
            bus_write  = 1'b1;
            bus_in     = {delay_val, CMD_SET_DELAY};
            state_next = W_STOP;
         end
         W_STOP: begin
            bus_write  = 1'b1;
            bus_in     = {stop_addr, CMD_SET_STOP};
            state_next = S_VALID;
         end
         S_VALID: begin
            bus_write  = 1'b1;
            bus_in     = {{(BUSW-3){1'b0}}, CMD_GET_VALID};
            state_next = R_VALID;
         end
         R_VALID: begin
            if (out_free) begin
               bus_read = 1'b1;
               if (bus_out[0]) begin
                  state_next = S_WIDTH;
               end else begin
`ifdef SCOPE_READER_TIMEOUT_EN
                  if (poll_cnt_reg == PCW'(TIMEOUT - 1)) begin
                     err_next   = 1'b1;
                     state_next = DONE;
                  end else begin
                     poll_cnt_next = poll_cnt_reg + 1'b1;
                     gap_cnt_next  = '0;
                     state_next    = GAP;
                  end
`else
                  gap_cnt_next = '0;
                  state_next   = GAP;
`endif
               end
            end
         end
         GAP: begin
            // The scope keeps GET_VALID selected, so the gap returns straight to the read.
            if (gap_cnt_reg == GAPW'(POLL_GAP - 1)) state_next = R_VALID;
            else gap_cnt_next = gap_cnt_reg + 1'b1;
         end
         S_WIDTH: begin
            bus_write  = 1'b1;
            bus_in     = {{(BUSW-3){1'b0}}, CMD_GET_WIDTH};
            state_next = R_WIDTH;
         end
         R_WIDTH: begin
            if (out_free) begin
               bus_read       = 1'b1;
               out_valid_next = 1'b1;
               out_data_next  = bus_out;
               out_tag_next   = TAG_HDR;
               out_last_next  = 1'b0;
               wps_next       = wps_calc;
               state_next     = S_COUNT;
            end
         end
         S_COUNT: begin
            bus_write  = 1'b1;
            bus_in     = {{(BUSW-3){1'b0}}, CMD_GET_COUNT};
            state_next = R_COUNT;
         end
         R_COUNT: begin
            if (out_free) begin
               bus_read       = 1'b1;
               out_valid_next = 1'b1;
               out_data_next  = bus_out;
               out_tag_next   = TAG_HDR;
               out_last_next  = 1'b0;
               count_next     = bus_out[CNTW-1:0];
               state_next     = (bus_out[CNTW-1:0] == '0) ? DONE : S_OFFSET;
            end
         end
         S_OFFSET: begin
            bus_write  = 1'b1;
            bus_in     = {{(BUSW-3){1'b0}}, CMD_GET_OFFSET};
            state_next = R_OFFSET;
         end
         R_OFFSET: begin
            if (out_free) begin
               bus_read        = 1'b1;
               out_valid_next  = 1'b1;
               out_data_next   = bus_out;
               out_tag_next    = TAG_HDR;
               out_last_next   = 1'b0;
               word_idx_next   = '0;
               sample_idx_next = '0;
               state_next      = S_DATA;
            end
         end
         S_DATA: begin
            bus_write  = 1'b1;
            bus_in     = {{(BUSW-3){1'b0}}, CMD_GET_DATA};
            state_next = R_DATA;
         end
         R_DATA: begin
            if (out_free) begin
               bus_read       = 1'b1;
               out_valid_next = 1'b1;
               out_data_next  = bus_out;
               out_tag_next   = (word_idx_reg == '0) ? TAG_DELTA : TAG_DATA;
               out_last_next  = last_word;
               if (last_word) begin
                  state_next = DONE;
               end else if (word_idx_reg == wps_reg - 1'b1) begin
                  word_idx_next   = '0;
                  sample_idx_next = sample_idx_reg + 1'b1;
               end else begin
                  word_idx_next = word_idx_reg + 1'b1;
               end
            end
         end
         DONE: begin
            // Wait until the final word leaves the output register.
            if (out_free) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         out_tag_reg    <= '0;
         out_last_reg   <= 1'b0;
         done_reg       <= 1'b0;
         gap_cnt_reg    <= '0;
         wps_reg        <= '0;
         count_reg      <= '0;
         word_idx_reg   <= '0;
         sample_idx_reg <= '0;
`ifdef SCOPE_READER_TIMEOUT_EN
         poll_cnt_reg   <= '0;
         err_reg        <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         out_valid_reg  <= out_valid_next;
         out_data_reg   <= out_data_next;
         out_tag_reg    <= out_tag_next;
         out_last_reg   <= out_last_next;
         done_reg       <= done_next;
         gap_cnt_reg    <= gap_cnt_next;
         wps_reg        <= wps_next;
         count_reg      <= count_next;
         word_idx_reg   <= word_idx_next;
         sample_idx_reg <= sample_idx_next;
`ifdef SCOPE_READER_TIMEOUT_EN
         poll_cnt_reg   <= poll_cnt_next;
         err_reg        <= err_next;
`endif
      end
   end

endmodule

// File: tb/tb_scope_reader.sv
// Directed bench for scope_reader: behavioural scope model, stream monitor and per-session checks.
// With SCOPE_READER_TIMEOUT_EN defined the poll-timeout abort is exercised as well.
module tb_scope_reader;

   logic        clk;
   logic        reset;
   logic        start;
   logic [60:0] delay_val, stop_addr;
   logic [63:0] bus_in, bus_out, out_data;
   logic        bus_write, bus_read, out_valid, out_ready, out_last, busy, done, err;
   logic [1:0]  out_tag;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   scope_reader #(.BUSW(64), .CNTW(16), .POLL_GAP(16), .TIMEOUT(5)) dut (
      .clk(clk), .reset(reset), .start(start), .delay_val(delay_val), .stop_addr(stop_addr),
      .bus_in(bus_in), .bus_write(bus_write), .bus_read(bus_read), .bus_out(bus_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .out_last(out_last), .busy(busy), .done(done), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Scope model: registered command select, combinational read data.
   logic [2:0] sc_sel = 3'd7;
   int sc_ptr = 0, sc_vpolls = 0;
   int sc_width, sc_count, sc_inv, sc_offset;
   logic model_clear;

   function automatic logic [63:0] pat(input int p);
      return {32'hD00D_0000 + 32'(p), ~32'(p)};
   endfunction

   always @(posedge clk) begin
      if (model_clear) begin
         sc_ptr    <= 0;
         sc_vpolls <= 0;
      end else begin
         if (bus_read && sc_sel == 3'd1) sc_ptr <= sc_ptr + 1;
         if (bus_read && sc_sel == 3'd0) sc_vpolls <= sc_vpolls + 1;
      end
      if (bus_write) sc_sel <= bus_in[2:0];
   end

   always_comb begin
      bus_out = '0;
      case (sc_sel)
         3'd0: bus_out = {63'd0, (sc_vpolls >= sc_inv)};
         3'd1: bus_out = pat(sc_ptr);
         3'd2: bus_out = 64'(sc_width);
         3'd3: bus_out = 64'(sc_count);
         3'd6: bus_out = 64'(sc_offset);
         default: bus_out = '0;
      endcase
   end

   // Monitor
   typedef struct {
      logic [1:0]  tag;
      logic        last;
      logic [63:0] data;
      int          cyc;
   } hs_t;
   hs_t         hs_q[$];
   int          poll_q[$];
   logic [63:0] wr_q[$];
   int          wr_cyc_q[$];
   int          done_q[$];
   int          stall_viol = 0;
   int          data_rd = 0;

   always @(negedge clk) begin
      if (reset) begin
         if (out_valid && out_ready) hs_q.push_back('{out_tag, out_last, out_data, cyc});
         if (bus_read && sc_sel == 3'd0) poll_q.push_back(cyc);
         if (bus_read && sc_sel == 3'd1) data_rd <= data_rd + 1;
         if (bus_write) begin
            wr_q.push_back(bus_in);
            wr_cyc_q.push_back(cyc);
         end
         if (done) done_q.push_back(cyc);
         if (bus_read && out_valid && !out_ready) stall_viol <= stall_viol + 1;
      end
   end

   bit rand_ready = 1'b0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      check_val($sformatf("%s_bus_in", nm), bus_in, 64'd0);
      check_val($sformatf("%s_out_data", nm), out_data, 64'd0);
      check_val($sformatf("%s_ctrl", nm),
                {bus_write, bus_read, out_valid, out_tag, out_last, busy, done, err}, 64'd0);
   endtask

   int hb, pb, wb, db, cs;

   task automatic start_session(input int w, input int c, input int inv, input int off);
      sc_width  = w;
      sc_count  = c;
      sc_inv    = inv;
      sc_offset = off;
      delay_val = 61'(64'h0DE1_A700_0000_0000 + 64'(w));
      stop_addr = 61'(64'h0570_0000_0000_0000 + 64'(c));
      model_clear = 1'b1;
      @(posedge clk);
      #1;
      model_clear = 1'b0;
      hb = hs_q.size();
      pb = poll_q.size();
      wb = wr_q.size();
      db = done_q.size();
      start = 1'b1;
      cs = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (done_q.size() == db && n < 4000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val($sformatf("%s_done_seen", nm), 64'(done_q.size() > db), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check_val($sformatf("%s_done_pulses", nm), 64'(done_q.size() - db), 64'd1);
      check_val($sformatf("%s_busy_after", nm), 64'(busy), 64'd0);
   endtask

   task automatic run_and_check(input string nm, input int w, input int c, input int inv, input int off);
      int chunks, wps, nexp, nact, j, lasti;
      logic [1:0]  et;
      logic        el;
      logic [63:0] ed;
      start_session(w, c, inv, off);
      check_val($sformatf("%s_err_clear", nm), 64'(err), 64'd0);
      wait_done(nm);
      chunks = (w + 63) / 64;
      wps    = 1 + ((chunks < 1) ? 1 : chunks);
      nexp   = 3 + c * wps;
      nact   = hs_q.size() - hb;
      check_val($sformatf("%s_nwords", nm), 64'(nact), 64'(nexp));
      for (int i = 0; i < nexp && i < nact; i++) begin
         if (i < 3) begin
            et = 2'd0;
            el = 1'b0;
            ed = (i == 0) ? 64'(w) : (i == 1) ? 64'(c) : 64'(off);
         end else begin
            j  = i - 3;
            et = ((j % wps) == 0) ? 2'd1 : 2'd2;
            el = (j == c * wps - 1);
            ed = pat(j);
         end
         check_val($sformatf("%s_w%0d_tag_last", nm, i), {hs_q[hb+i].tag, hs_q[hb+i].last}, {et, el});
         check_val($sformatf("%s_w%0d_data", nm, i), hs_q[hb+i].data, ed);
      end
      if (nact > 0 && done_q.size() > db) begin
         lasti = hs_q.size() - 1;
         check_val($sformatf("%s_done_lat", nm), 64'(done_q[db] - hs_q[lasti].cyc), 64'd1);
      end
      check_val($sformatf("%s_nwrites", nm), 64'(wr_q.size() - wb), 64'd7);
      if (wr_q.size() - wb >= 7) begin
         check_val($sformatf("%s_wr_delay", nm), wr_q[wb], {delay_val, 3'd4});
         check_val($sformatf("%s_wr_stop", nm), wr_q[wb+1], {stop_addr, 3'd5});
         check_val($sformatf("%s_wr_codes", nm),
                   {wr_q[wb+2][2:0], wr_q[wb+3][2:0], wr_q[wb+4][2:0], wr_q[wb+5][2:0], wr_q[wb+6][2:0]},
                   {3'd0, 3'd2, 3'd3, 3'd6, 3'd1});
         check_val($sformatf("%s_start_lat", nm), 64'(wr_cyc_q[wb] - cs), 64'd1);
      end
      check_val($sformatf("%s_npolls", nm), 64'(poll_q.size() - pb), 64'(inv + 1));
      for (int k = pb; k + 1 < poll_q.size(); k++)
         check_val($sformatf("%s_poll_gap%0d", nm, k - pb), 64'(poll_q[k+1] - poll_q[k]), 64'd17);
      check_val($sformatf("%s_data_reads", nm), 64'(sc_ptr), 64'(c * wps));
   endtask

   initial begin
      int n, base;
      reset       = 1'b0;
      start       = 1'b0;
      model_clear = 1'b1;
      delay_val   = '0;
      stop_addr   = '0;
      sc_width = 0; sc_count = 0; sc_inv = 0; sc_offset = 0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      reset = 1'b1;
      model_clear = 1'b0;
      @(posedge clk);
      #1;

      run_and_check("w32c4", 32, 4, 0, 16'h1234);
      run_and_check("w100c2", 100, 2, 0, 7);
      run_and_check("poll3", 32, 1, 3, 3);
      rand_ready = 1'b1;
      run_and_check("rdy_rand", 32, 4, 0, 16'h1234);
      rand_ready = 1'b0;
      check_val("no_read_while_stalled", 64'(stall_viol), 64'd0);

      // Asynchronous reset in the middle of the data phase.
      start_session(32, 4, 0, 9);
      base = data_rd;
      n = 0;
      while (data_rd < base + 3 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("rst_reached_data", 64'(data_rd >= base + 3), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_busy_after", 64'(busy), 64'd0);
      run_and_check("after_rst_w129", 129, 1, 0, 5);

`ifdef SCOPE_READER_TIMEOUT_EN
      start_session(32, 4, 32'h7FFF_FFFF, 0);
      wait_done("tmo");
      check_val("tmo_err", 64'(err), 64'd1);
      check_val("tmo_npolls", 64'(poll_q.size() - pb), 64'd5);
      check_val("tmo_nwords", 64'(hs_q.size() - hb), 64'd0);
      run_and_check("tmo_next", 32, 1, 0, 2);
`else
      check_val("err_tied_low", 64'(err), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
